bitwise_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit bitwise logic unit (OR/AND/XOR/NOT, built from the layer-1 16-bit gate arrays) between up to eight requesters. Each requester presents two operands and an opcode under a valid/ready handshake. The block grants one requester per cycle, computes the result, and holds it in a single output register until the consumer accepts it. It sits between the layer-1 gate arrays and the higher-level datapath blocks that need bitwise operations without each instantiating their own.

---
 rtl/bitwise_arbiter.sv | 117 +++++++++++
 tb/tb_bitwise_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_arbiter.sv
// bitwise_arbiter: round-robin share of one 16-bit OR/AND/XOR/NOT unit; XOR is built only under `BITWISE_ARBITER_XOR_EN.
// Latency: accepted in cycle T, rsp_valid in T+1; one result per cycle with same-cycle accept and drain.
// Backpressure: rsp_valid && !rsp_ready holds the result register and drops every req_ready.
module bitwise_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [0:N_REQ*16-1] req_a,
  input  logic [0:N_REQ*16-1] req_b,
  input  logic [0:N_REQ*2-1]  req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [0:15]         rsp_out,
  output logic [2:0]          rsp_id,
  output logic                rsp_err
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  logic [2:0]  ptr;
  logic [2:0]  grant;
  logic        grant_vld;
  logic        can_accept;
  logic        xfer;
  logic [0:15] sel_a;
  logic [0:15] sel_b;
  logic [1:0]  sel_op;
  logic [0:15] alu_res;
  logic        alu_err;

  // Index reached after stepping off positions past base, wrapping at N_REQ.
  function automatic logic [2:0] rr_index(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[2:0];
  endfunction

  // Walk farthest offset first so the nearest valid requester to ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && (rr_index(ptr, k) == i[2:0])) begin
          grant     = i[2:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign xfer       = grant_vld && can_accept && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer && (grant == i[2:0])) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == i[2:0]) begin
        sel_a  = req_a[i*16 +: 16];
        sel_b  = req_b[i*16 +: 16];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (sel_op)
      OP_OR:  alu_res = sel_a | sel_b;
      OP_AND: alu_res = sel_a & sel_b;
`ifdef BITWISE_ARBITER_XOR_EN
      OP_XOR: alu_res = sel_a ^ sel_b;
`else
      // Still consumes the grant so the requester is not stuck; flagged instead.
      OP_XOR: alu_err = 1'b1;
`endif
      OP_NOT: alu_res = ~sel_a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_out   <= alu_res;
      rsp_id    <= grant;
      rsp_err   <= alu_err;
      ptr       <= (grant == 3'(N_REQ - 1)) ? 3'd0 : grant + 3'd1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Directed bench for bitwise_arbiter (N_REQ=4): reset, basic op, round robin, stall, opcodes, reset mid-flight.
module tb_bitwise_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [0:63] req_a;
  logic [0:63] req_b;
  logic [0:7]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:15] rsp_out;
  logic [2:0]  rsp_id;
  logic        rsp_err;

  int checks;
  int errors;

  bitwise_arbiter #(.N_REQ(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_valid[i]       = 1'b1;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
    req_op[i*2 +: 2]   = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", rsp_out); end
    checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 16'hF0F0, 16'h0F0F, 2'b00);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_out !== 16'hFFFF) begin errors++; $display("FAIL basic_out got %h want FFFF", rsp_out); end
    checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL basic_id got %0d want 0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", rsp_err); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int exp_id;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 16'h1000 + 16'(i), 16'h0000, 2'b00);
    for (int k = 0; k < 6; k++) begin
      exp_id  = k % 4;
      exp_rdy = 4'b0001 << exp_id;
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (rsp_id !== 3'(exp_id) || rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_id[%0d] got %0d/%b want %0d/1", k, rsp_id, rsp_valid, exp_id); end
      checks++; if (rsp_out !== 16'h1000 + 16'(exp_id)) begin errors++; $display("FAIL rr_out[%0d] got %h want %h", k, rsp_out, 16'h1000 + 16'(exp_id)); end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(2, 16'h1234, 16'hFFFF, 2'b01);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_first_ready got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    set_req(0, 16'h0001, 16'h0000, 2'b00);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_out !== 16'h1234 || rsp_id !== 3'd2) begin
        errors++; $display("FAIL stall_hold[%0d] got %b %h %0d want 1 1234 2", k, rsp_valid, rsp_out, rsp_id);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_out !== 16'h0001 || rsp_id !== 3'd0) begin
      errors++; $display("FAIL stall_next got %b %h %0d want 1 0001 0", rsp_valid, rsp_out, rsp_id);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [15:0] exp_xor;
    logic        exp_err;
`ifdef BITWISE_ARBITER_XOR_EN
    exp_xor = 16'h5555;
    exp_err = 1'b0;
`else
    exp_xor = 16'h0000;
    exp_err = 1'b1;
`endif
    rsp_ready = 1'b1;
    set_req(1, 16'h00FF, 16'h1234, 2'b11);
    @(posedge clk); #1;
    checks++; if (rsp_out !== 16'hFF00 || rsp_id !== 3'd1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL op_not got %h id %0d err %b want FF00 id 1 err 0", rsp_out, rsp_id, rsp_err);
    end
    @(negedge clk);
    req_valid = '0;
    set_req(3, 16'hAAAA, 16'hFFFF, 2'b10);
    @(posedge clk); #1;
    checks++; if (rsp_out !== exp_xor || rsp_id !== 3'd3) begin
      errors++; $display("FAIL op_xor got %h id %0d want %h id 3", rsp_out, rsp_id, exp_xor);
    end
    checks++; if (rsp_err !== exp_err) begin errors++; $display("FAIL op_xor_err got %b want %b", rsp_err, exp_err); end
    @(negedge clk);
    req_valid = '0;
    set_req(0, 16'hAAAA, 16'h0FF0, 2'b01);
    @(posedge clk); #1;
    checks++; if (rsp_out !== 16'h0AA0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL op_and got %h err %b want 0AA0 err 0", rsp_out, rsp_err);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(1, 16'h00F0, 16'h0000, 2'b11);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_out !== 16'hFF0F) begin
      errors++; $display("FAIL mid_setup got %b %0d %h want 1 1 FF0F", rsp_valid, rsp_id, rsp_out);
    end
    #1;
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_out !== 16'h0000 || rsp_id !== 3'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %b %h %0d %b want 0 0000 0 0", rsp_valid, rsp_out, rsp_id, rsp_err);
    end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got %b want 0000", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_after_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0) begin
      errors++; $display("FAIL mid_after_id got %b %0d want 1 0", rsp_valid, rsp_id);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_ops();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
